// File: rtl/vxe_txn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vxe_txn_pkg
// Purpose  : Shared widths and half-select constants for VxE request encoders.
// Revision : 1.0
// ============================================================================
package vxe_txn_pkg;
   localparam int VXE_TXN_REQD_W  = 72;
   localparam int VXE_TXN_BEN_LSB = 64;
   localparam int VXE_TXN_DATA_W  = 64;

   localparam logic LO = 1'b0;
   localparam logic HI = 1'b1;
endpackage
`default_nettype wire

// File: rtl/vxe_txnreqd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vxe_txnreqd_fifo
// Purpose  : Parameterised synchronous FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module vxe_txnreqd_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_dat,
   output logic [CW-1:0]    o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // A push is refused at full even if a pop happens in the same cycle.
   assign w_push  = i_push && (r_count != CW'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   assign o_vld   = (r_count != '0);
   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/vxe_txnreqd_packer.sv
`default_nettype none
// ============================================================================
// Module   : vxe_txnreqd_packer
// Purpose  : Packs 32-bit store words into 72-bit request data beats.
// Revision : 1.0
// ============================================================================
module vxe_txnreqd_packer
   import vxe_txn_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_wr_vld,
   output logic                      o_wr_rdy,
   input  logic [31:0]               i_wr_data,
   input  logic [3:0]                i_wr_ben,
   input  logic                      i_wr_hi,
   input  logic                      i_wr_last,
   output logic [VXE_TXN_REQD_W-1:0] o_req_vec_dat,
   output logic                      o_req_vld,
   input  logic                      i_req_rdy
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [VXE_TXN_DATA_W-1:0] r_acc_data;
   logic [7:0]                r_acc_ben;
   logic [1:0]                r_used;
   logic                      r_flush_pend;

   logic [VXE_TXN_DATA_W-1:0] w_acc_data;
   logic [7:0]                w_acc_ben;
   logic [1:0]                w_used;
   logic                      w_flush_pend;
   logic [VXE_TXN_DATA_W-1:0] w_word_data;
   logic [7:0]                w_word_ben;
   logic [1:0]                w_word_oh;
   logic                      w_used_tgt;
   logic                      w_used_oth;
   logic                      w_push;
   logic [VXE_TXN_REQD_W-1:0] w_push_dat;
   logic                      w_accept;
   logic                      w_full;
   logic [CW-1:0]             w_count;

   assign w_full   = (w_count == CW'(DEPTH));
   assign o_wr_rdy = !w_full && !r_flush_pend;
   assign w_accept = i_wr_vld && o_wr_rdy;

   // Incoming word placed in its target half, other half zeroed.
   assign w_word_data = (i_wr_hi == HI) ? {i_wr_data, 32'h0} : {32'h0, i_wr_data};
   assign w_word_ben  = (i_wr_hi == HI) ? {i_wr_ben, 4'h0}   : {4'h0, i_wr_ben};
   assign w_word_oh   = (i_wr_hi == HI) ? 2'b10 : 2'b01;
   assign w_used_tgt  = (i_wr_hi == HI) ? r_used[HI] : r_used[LO];
   assign w_used_oth  = (i_wr_hi == HI) ? r_used[LO] : r_used[HI];

   always_comb begin
      w_acc_data   = r_acc_data;
      w_acc_ben    = r_acc_ben;
      w_used       = r_used;
      w_flush_pend = r_flush_pend;
      w_push       = 1'b0;
      w_push_dat   = {r_acc_ben, r_acc_data};
      if (r_flush_pend) begin
         if (!w_full) begin
            w_push       = 1'b1;
            w_acc_data   = '0;
            w_acc_ben    = '0;
            w_used       = '0;
            w_flush_pend = 1'b0;
         end
      end else if (w_accept) begin
         if (!w_used_tgt) begin
            if (i_wr_last || w_used_oth) begin
               w_push     = 1'b1;
               w_push_dat = {r_acc_ben | w_word_ben, r_acc_data | w_word_data};
               w_acc_data = '0;
               w_acc_ben  = '0;
               w_used     = '0;
            end else begin
               w_acc_data = r_acc_data | w_word_data;
               w_acc_ben  = r_acc_ben | w_word_ben;
               w_used     = r_used | w_word_oh;
            end
         end else begin
            // Collision: emit what we have and restart with the new word.
            w_push       = 1'b1;
            w_acc_data   = w_word_data;
            w_acc_ben    = w_word_ben;
            w_used       = w_word_oh;
            w_flush_pend = i_wr_last;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_data   <= '0;
         r_acc_ben    <= '0;
         r_used       <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_acc_data   <= w_acc_data;
         r_acc_ben    <= w_acc_ben;
         r_used       <= w_used;
         r_flush_pend <= w_flush_pend;
      end
   end

   vxe_txnreqd_fifo #(
      .WIDTH (VXE_TXN_REQD_W),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (i_req_rdy),
      .o_vld      (o_req_vld),
      .o_dat      (o_req_vec_dat),
      .o_count    (w_count)
   );
endmodule
`default_nettype wire

// File: tb/tb_vxe_txnreqd_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vxe_txnreqd_packer
// Purpose  : Directed stimulus with a queued-expectation scoreboard.
// Revision : 1.0
// ============================================================================
module tb_vxe_txnreqd_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_vld = 1'b0;
   logic        wr_rdy;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_ben = '0;
   logic        wr_hi = 1'b0;
   logic        wr_last = 1'b0;
   logic [71:0] req_dat;
   logic        req_vld;
   logic        req_rdy = 1'b1;

   int n_cmp = 0;
   int n_err = 0;
   logic [71:0] exp_q [$];

   always #5 clk = ~clk;

   vxe_txnreqd_packer #(.DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_wr_vld      (wr_vld),
      .o_wr_rdy      (wr_rdy),
      .i_wr_data     (wr_data),
      .i_wr_ben      (wr_ben),
      .i_wr_hi       (wr_hi),
      .i_wr_last     (wr_last),
      .o_req_vec_dat (req_dat),
      .o_req_vld     (req_vld),
      .i_req_rdy     (req_rdy)
   );

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every beat handed to the consumer must match the queue head.
   always @(negedge clk) begin
      if (!rst && req_vld && req_rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", req_dat, 72'h0);
            if (req_dat == 72'h0) begin
               n_err++;
               $display("FAIL unexpected_beat: got %h expected none", req_dat);
            end
         end else begin
            check("beat", req_dat, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [3:0] b, input logic h, input logic l);
      bit ok = 0;
      wr_vld  = 1'b1;
      wr_data = d;
      wr_ben  = b;
      wr_hi   = h;
      wr_last = l;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (wr_rdy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("send_timeout", 72'h0, 72'h1);
      @(posedge clk);
      #1;
      wr_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      idle(3);
      check("reset_vld", {71'h0, req_vld}, 72'h0);
      check("reset_dat", req_dat, 72'h0);
      check("reset_rdy", {71'h0, wr_rdy}, 72'h1);
      rst = 1'b0;
      idle(1);

      // lo + hi pair merges into one beat, visible the cycle after the hi accept
      exp_q.push_back(72'h3F_AABBCCDD_11223344);
      send(32'h11223344, 4'hF, 1'b0, 1'b0);
      check("pair_not_early", {71'h0, req_vld}, 72'h0);
      send(32'hAABBCCDD, 4'h3, 1'b1, 1'b0);
      check("pair_latency_vld", {71'h0, req_vld}, 72'h1);
      check("pair_latency_dat", req_dat, 72'h3F_AABBCCDD_11223344);
      idle(2);

      // single hi word with last
      exp_q.push_back(72'hC0_DEADBEEF_00000000);
      send(32'hDEADBEEF, 4'hC, 1'b1, 1'b1);
      idle(2);

      // collision on lo half with last on the second word
      exp_q.push_back(72'h01_00000000_00000001);
      exp_q.push_back(72'h0F_00000000_00000002);
      send(32'h00000001, 4'h1, 1'b0, 1'b0);
      send(32'h00000002, 4'hF, 1'b0, 1'b1);
      check("collision_rdy_low", {71'h0, wr_rdy}, 72'h0);
      idle(1);
      check("collision_rdy_back", {71'h0, wr_rdy}, 72'h1);
      idle(3);

      // backpressure: three pairs offered with consumer stalled
      req_rdy = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back({8'hFF, 32'h20000000 | 32'(k), 32'h10000000 | 32'(k)});
      end
      fork
         begin
            for (int k = 1; k <= 3; k++) begin
               send(32'h10000000 | 32'(k), 4'hF, 1'b0, 1'b0);
               send(32'h20000000 | 32'(k), 4'hF, 1'b1, 1'b0);
            end
         end
         begin
            idle(10);
            check("bp_rdy_low", {71'h0, wr_rdy}, 72'h0);
            check("bp_head_vld", {71'h0, req_vld}, 72'h1);
            check("bp_head", req_dat, 72'hFF_20000001_10000001);
            idle(3);
            check("bp_head_stable", req_dat, 72'hFF_20000001_10000001);
            req_rdy = 1'b1;
         end
      join
      idle(4);
      check("bp_drained", 72'(exp_q.size()), 72'h0);

      // steady push+pop at count 1: one beat per cycle
      req_rdy = 1'b0;
      exp_q.push_back(72'h05_00000000_50000000);
      send(32'h50000000, 4'h5, 1'b0, 1'b1);
      req_rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if (k % 2 == 1) exp_q.push_back({8'h50, 32'h50000000 | 32'(k), 32'h0});
         else            exp_q.push_back({8'h05, 32'h0, 32'h50000000 | 32'(k)});
         send(32'h50000000 | 32'(k), 4'h5, (k % 2 == 1), 1'b1);
         check("steady_vld", {71'h0, req_vld}, 72'h1);
         check("steady_rdy", {71'h0, wr_rdy}, 72'h1);
      end
      idle(3);

      // reset with a queued beat and a lo half accumulated: both dropped
      req_rdy = 1'b0;
      send(32'h77777777, 4'hF, 1'b0, 1'b0);
      send(32'h88888888, 4'hF, 1'b1, 1'b0);
      send(32'h99999999, 4'hF, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_vld", {71'h0, req_vld}, 72'h0);
      check("rst_async_rdy", {71'h0, wr_rdy}, 72'h1);
      idle(2);
      rst = 1'b0;
      req_rdy = 1'b1;
      exp_q.push_back(72'hF0_CAFEF00D_00000000);
      send(32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
      idle(4);

      check("queue_empty", 72'(exp_q.size()), 72'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
